// File: rtl/multi_param.sv
// -----------------------------------------------------------------------------
// multi_param
//   Parametrised fixed-latency iterative multiplier. It retires BPC multiplier
//   bits per clock using shift-add on operand magnitudes, then applies the
//   sign in a final DONE step. Every operation takes the same number of cycles.
//
// Parameters
//   WIDTH  operand width in bits (>=4, even)
//   BPC    multiplier bits retired per cycle (1, 2 or 4); WIDTH % BPC == 0
//
// Ports
//   clock   in   rising-edge clock
//   reset   in   asynchronous, active-low reset
//   mlier   in   [WIDTH-1:0]   multiplier operand
//   mcand   in   [WIDTH-1:0]   multiplicand operand
//   sgn     in   1 = two's-complement operands, 0 = unsigned (sampled at launch)
//   start   in   launch request; only a 0->1 transition launches
//   prodt   out  [2*WIDTH-1:0] product, held until the next completion
//   valid   out  one-cycle pulse when prodt is updated
//   busy    out  high from launch through the valid cycle
//
// Timing: a launch at edge L yields valid in the cycle after edge L+N+1,
// where N = WIDTH/BPC.
// -----------------------------------------------------------------------------
module multi_param #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     mlier,
  input  logic [WIDTH-1:0]     mcand,
  input  logic                 sgn,
  input  logic                 start,
  output logic [2*WIDTH-1:0]   prodt,
  output logic                 valid,
  output logic                 busy
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Unsigned magnitude of an operand. In signed mode the most negative value
  // maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             s);
    magnitude = (s && x[WIDTH-1]) ? -x : x;
  endfunction

  // Re-applies the result sign. Negating zero gives zero, so a zero operand
  // with opposite signs still produces a clean 0.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] m,
                                                    input logic               neg);
    apply_sign = neg ? -m : m;
  endfunction

  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic                start_q;
  logic                seen_low;   // start has been observed low since reset
  logic                launch;
  logic                step;

  logic [2*WIDTH-1:0]  acc_p1;      // {partial high, remaining multiplier bits}
  logic [WIDTH-1:0]    mcand_mag_p1;
  logic                neg_p1;

  logic [BPC-1:0]         digit;
  logic [WIDTH+BPC-1:0]   pp;
  logic [WIDTH+BPC-1:0]   hi_sum;
  logic [2*WIDTH+BPC-1:0] acc_ext;
  logic [2*WIDTH-1:0]     acc_next;

  // seen_low keeps a start level held high across reset from counting as a
  // rising edge once the history register has been cleared.
  assign launch = (state == IDLE) && start && !start_q && seen_low;
  assign step   = (state == RUN);

  always_comb begin
    digit    = acc_p1[BPC-1:0];
    pp       = {{BPC{1'b0}}, mcand_mag_p1} * {{WIDTH{1'b0}}, digit};
    hi_sum   = {{BPC{1'b0}}, acc_p1[2*WIDTH-1:WIDTH]} + pp;
    acc_ext  = {hi_sum, acc_p1[WIDTH-1:0]};
    acc_next = acc_ext[2*WIDTH+BPC-1:BPC];
  end

  // ---- control: sequencing, handshake and result register ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      start_q  <= 1'b0;
      seen_low <= 1'b0;
      prodt    <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      start_q <= start;
      if (!start) seen_low <= 1'b1;
      case (state)
        IDLE: begin
          if (launch) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == LAST) state <= DONE;
          else             cnt   <= cnt + CW'(1);
        end
        DONE: begin
          // DONE spans two edges: the first publishes the product, the
          // second closes the handshake, so a start rise here is ignored.
          if (!valid) begin
            prodt <= apply_sign(acc_p1, neg_p1);
            valid <= 1'b1;
          end else begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- datapath p1: latched magnitudes and shift-add accumulator ----
  always_ff @(posedge clock) begin
    if (launch) begin
      acc_p1       <= {{WIDTH{1'b0}}, magnitude(mlier, sgn)};
      mcand_mag_p1 <= magnitude(mcand, sgn);
      neg_p1       <= sgn & (mlier[WIDTH-1] ^ mcand[WIDTH-1]);
    end else if (step) begin
      acc_p1       <= acc_next;
    end
  end

endmodule

// File: tb/tb_multi_param.sv
module tb_multi_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset = 1'b1;

  logic [31:0] a32 = '0, b32 = '0;
  logic        s32 = 1'b0, st32 = 1'b0;
  logic [63:0] p32;
  logic        v32, bz32;

  logic [15:0] a16 = '0, b16 = '0;
  logic        s16 = 1'b0, st16 = 1'b0;
  logic [31:0] p16;
  logic        v16, bz16;

  logic [7:0]  a8 = '0, b8 = '0;
  logic        s8 = 1'b0, st8 = 1'b0;
  logic [15:0] p8;
  logic        v8, bz8;

  multi_param #(.WIDTH(32), .BPC(1)) u32 (
    .clock(clock), .reset(reset), .mlier(a32), .mcand(b32), .sgn(s32),
    .start(st32), .prodt(p32), .valid(v32), .busy(bz32));

  multi_param #(.WIDTH(16), .BPC(4)) u16 (
    .clock(clock), .reset(reset), .mlier(a16), .mcand(b16), .sgn(s16),
    .start(st16), .prodt(p16), .valid(v16), .busy(bz16));

  multi_param #(.WIDTH(8), .BPC(2)) u8 (
    .clock(clock), .reset(reset), .mlier(a8), .mcand(b8), .sgn(s8),
    .start(st8), .prodt(p8), .valid(v8), .busy(bz8));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int          sel = 0;
  logic        cur_v, cur_b;
  logic [63:0] cur_p;
  always_comb begin
    cur_v = v32; cur_b = bz32; cur_p = p32;
    case (sel)
      1: begin cur_v = v16; cur_b = bz16; cur_p = {32'b0, p16}; end
      2: begin cur_v = v8;  cur_b = bz8;  cur_p = {48'b0, p8};  end
      default: ;
    endcase
  end

  // Launch one operation, release start, scramble operands, and check
  // latency, product and handshake.
  task automatic run_op(input int inst, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic [63:0] exp, input string tag);
    int lat_exp;
    int k;
    bit seen;
    bit busy_ok;
    sel = inst;
    lat_exp = (inst == 0) ? 33 : 5;
    @(negedge clock);
    case (inst)
      0: begin a32 = a[31:0]; b32 = b[31:0]; s32 = s; st32 = 1'b1; end
      1: begin a16 = a[15:0]; b16 = b[15:0]; s16 = s; st16 = 1'b1; end
      default: begin a8 = a[7:0]; b8 = b[7:0]; s8 = s; st8 = 1'b1; end
    endcase
    @(negedge clock);
    st32 = 1'b0; st16 = 1'b0; st8 = 1'b0;
    a32 = ~a32; b32 = b32 + 32'd3; a16 = ~a16; b16 = b16 + 16'd3;
    a8 = ~a8; b8 = b8 + 8'd3; s32 = ~s32; s16 = ~s16; s8 = ~s8;
    check({tag, "_busy_launch"}, 64'(cur_b), 64'd1);
    k = 0; seen = 0; busy_ok = 1;
    while (!seen && k < lat_exp + 8) begin
      @(negedge clock);
      k++;
      if (cur_v) seen = 1;
      else if (cur_b !== 1'b1) busy_ok = 0;
    end
    check({tag, "_latency"}, 64'(k), 64'(lat_exp));
    check({tag, "_prodt"}, cur_p, exp);
    check({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    check({tag, "_busy_valid"}, 64'(cur_b), 64'd1);
    @(negedge clock);
    check({tag, "_valid_off"}, 64'(cur_v), 64'd0);
    check({tag, "_busy_off"}, 64'(cur_b), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    int vk;
    logic [63:0] vp;
    logic hit;

    // Reset state, with start held high through reset
    st32 = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_prodt", p32, 64'd0);
    check("rst_valid", 64'(v32), 64'd0);
    check("rst_busy", 64'(bz32), 64'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("held_high_no_launch", 64'(bz32), 64'd0);
    st32 = 1'b0;
    repeat (2) @(negedge clock);

    // Zero operand, latency 33
    run_op(0, 64'd147483646, 64'd0, 1'b1, 64'd0, "zero");
    // Signed back-to-back
    run_op(0, 64'd147483646, 64'd1, 1'b1, 64'd147483646, "pos_x_1");
    run_op(0, -64'sd147483646, -64'sd1, 1'b1, 64'd147483646, "neg_x_neg1");
    run_op(0, 64'd147483646, -64'sd1, 1'b1, -64'sd147483646, "pos_x_neg1");
    run_op(0, -64'sd10, -64'sd12345, 1'b1, 64'd123450, "m10_x_m12345");
    run_op(0, 64'h8000_0000, 64'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "minneg_sq");
    // Unsigned vs signed all-ones
    run_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "ones_uns");
    run_op(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 64'd1, "ones_sgn");

    // Second rising edge during a run is ignored; held-high start -> one valid
    sel = 0;
    @(negedge clock);
    a32 = 32'd147483646; b32 = 32'd1; s32 = 1'b1; st32 = 1'b1;
    nv = 0; vk = -1; vp = '0;
    for (int k = 0; k < 110; k++) begin
      @(negedge clock);
      if (k == 5) st32 = 1'b0;
      if (k == 10) begin st32 = 1'b1; a32 = 32'd3; b32 = 32'd5; end
      if (v32) begin
        nv++;
        if (nv == 1) begin vk = k; vp = p32; end
      end
    end
    check("ign_valid_count", 64'(nv), 64'd1);
    check("ign_latency", 64'(vk), 64'd33);
    check("ign_prodt", vp, 64'd147483646);
    st32 = 1'b0;
    repeat (2) @(negedge clock);

    // Asynchronous reset mid-run
    @(negedge clock);
    a32 = 32'd5; b32 = 32'd7; s32 = 1'b1; st32 = 1'b1;
    @(negedge clock);
    st32 = 1'b0;
    repeat (14) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 64'(bz32), 64'd0);
    check("abort_valid", 64'(v32), 64'd0);
    check("abort_prodt", p32, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clock);
      if (v32 || bz32) hit = 1'b1;
    end
    check("abort_no_valid", 64'(hit), 64'd0);
    run_op(0, 64'd1, 64'd34222, 1'b1, 64'd34222, "relaunch");

    // Other parameter sets
    run_op(1, 64'hFFF9, 64'd9, 1'b1, 64'hFFFF_FFC1, "w16_m7_x_9");
    run_op(1, 64'hFFFB, 64'd0, 1'b1, 64'd0, "w16_neg_x_0");
    run_op(2, 64'd255, 64'd255, 1'b0, 64'd65025, "w8_255sq");
    run_op(2, 64'h80, 64'h80, 1'b1, 64'h4000, "w8_minneg_sq");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
